// File: rtl/alu_op_scheduler_if.sv
// Request, ALU, and TX FIFO write-port signals of alu_op_scheduler, named from the scheduler's side.
// The master modport is the scheduler. The slave modport is its environment.
interface alu_op_scheduler_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FUN_WIDTH   = 4,
  parameter int unsigned QUEUE_DEPTH = 4
);
  localparam int unsigned LvlW = $clog2(QUEUE_DEPTH) + 1;

  logic                    i_cmd_vld;
  logic [FUN_WIDTH-1:0]    i_cmd_fun;
  logic                    o_cmd_rdy;
  logic                    o_alu_clk_en;
  logic                    o_alu_en;
  logic [FUN_WIDTH-1:0]    o_alu_fun;
  logic [2*DATA_WIDTH-1:0] i_alu_out;
  logic                    i_alu_out_vld;
  logic                    i_fifo_full;
  logic [DATA_WIDTH-1:0]   o_wr_data;
  logic                    o_wr_inc;
  logic                    o_busy;
  logic                    o_timeout_err;
  logic [LvlW-1:0]         o_q_level;

  modport master (
    input  i_cmd_vld, i_cmd_fun, i_alu_out, i_alu_out_vld, i_fifo_full,
    output o_cmd_rdy, o_alu_clk_en, o_alu_en, o_alu_fun, o_wr_data, o_wr_inc, o_busy,
           o_timeout_err, o_q_level
  );

  modport slave (
    output i_cmd_vld, i_cmd_fun, i_alu_out, i_alu_out_vld, i_fifo_full,
    input  o_cmd_rdy, o_alu_clk_en, o_alu_en, o_alu_fun, o_wr_data, o_wr_inc, o_busy,
           o_timeout_err, o_q_level
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Queues ALU commands and issues them one at a time to the gated-clock ALU.
// Each 16-bit result is streamed into the TX FIFO as two bytes, low byte first.
module alu_op_scheduler #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FUN_WIDTH   = 4,
  parameter int unsigned QUEUE_DEPTH = 4,   // power of 2, >= 2
  parameter int unsigned ALU_TIMEOUT = 15   // 1..255
) (
  input logic                i_clk,
  input logic                i_rst,
  alu_op_scheduler_if.master bus
);
  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [7:0]  TimeoutLast = 8'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StGateOn, StIssue, StWait, StSendLo, StSendHi
  } state_e;

  state_e                  r_state, w_state_d;
  logic [FUN_WIDTH-1:0]    r_queue [QUEUE_DEPTH];
  logic [PtrW-1:0]         r_rd_ptr, r_wr_ptr;
  logic [LvlW-1:0]         r_level, w_level_d, w_lvl_after_pop;
  logic [7:0]              r_cnt, w_cnt_d;
  logic [2*DATA_WIDTH-1:0] r_result, w_result_d;
  logic [FUN_WIDTH-1:0]    r_last_fun;
  logic [FUN_WIDTH-1:0]    w_head;
  logic                    w_full, w_push, w_pop;
  logic                    w_wr_inc;
  logic [DATA_WIDTH-1:0]   w_wr_data;

  assign w_full          = (r_level == LvlW'(QUEUE_DEPTH));
  assign w_push          = bus.i_cmd_vld & ~w_full;
  assign w_head          = r_queue[r_rd_ptr];
  assign w_level_d       = r_level + LvlW'(w_push) - LvlW'(w_pop);
  // The pop paths use this. A concurrent push keeps the ALU clock running.
  assign w_lvl_after_pop = r_level - LvlW'(1) + LvlW'(w_push);

  assign bus.o_cmd_rdy = ~w_full;
  assign bus.o_busy    = (r_state != StIdle);
  assign bus.o_q_level = r_level;

  always_comb begin
    w_state_d         = r_state;
    w_cnt_d           = r_cnt;
    w_result_d        = r_result;
    w_pop             = 1'b0;
    w_wr_inc          = 1'b0;
    w_wr_data         = '0;
    bus.o_alu_clk_en  = 1'b0;
    bus.o_alu_en      = 1'b0;
    bus.o_alu_fun     = r_last_fun;
    bus.o_timeout_err = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_level != '0) w_state_d = StGateOn;
      end
      StGateOn: begin
        bus.o_alu_clk_en = 1'b1;
        w_state_d        = StIssue;
      end
      StIssue: begin
        bus.o_alu_clk_en = 1'b1;
        bus.o_alu_en     = 1'b1;
        bus.o_alu_fun    = w_head;
        w_cnt_d          = '0;
        w_state_d        = StWait;
      end
      StWait: begin
        bus.o_alu_clk_en = 1'b1;
        if (bus.i_alu_out_vld) begin
          w_result_d = bus.i_alu_out;
          w_state_d  = StSendLo;
        end else if (r_cnt == TimeoutLast) begin
          bus.o_timeout_err = 1'b1;
          w_pop             = 1'b1;
          w_state_d         = (w_lvl_after_pop != '0) ? StIssue : StIdle;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StSendLo: begin
        bus.o_alu_clk_en = 1'b1;
        if (!bus.i_fifo_full) begin
          w_wr_inc  = 1'b1;
          w_wr_data = r_result[DATA_WIDTH-1:0];
          w_state_d = StSendHi;
        end
      end
      StSendHi: begin
        bus.o_alu_clk_en = 1'b1;
        if (!bus.i_fifo_full) begin
          w_wr_inc  = 1'b1;
          w_wr_data = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
          w_pop     = 1'b1;
          w_state_d = (w_lvl_after_pop != '0) ? StIssue : StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // A reset arriving mid-send must not leak a write strobe in its own cycle.
  assign bus.o_wr_inc  = w_wr_inc & ~i_rst;
  assign bus.o_wr_data = i_rst ? '0 : w_wr_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_level    <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_last_fun <= '0;
    end else begin
      r_state  <= w_state_d;
      r_level  <= w_level_d;
      r_cnt    <= w_cnt_d;
      r_result <= w_result_d;
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (r_state == StIssue) r_last_fun <= w_head;
    end
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_queue[r_wr_ptr] <= bus.i_cmd_fun;
  end
endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler. It uses a reference model built on queues,
// a small ALU responder, and directed scenarios with literal timing checks.
module tb_alu_op_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   started = 1'b0;

  always #5 clk = ~clk;

  alu_op_scheduler_if #(.DATA_WIDTH(8), .FUN_WIDTH(4), .QUEUE_DEPTH(4)) bus ();

  alu_op_scheduler #(
    .DATA_WIDTH (8),
    .FUN_WIDTH  (4),
    .QUEUE_DEPTH(4),
    .ALU_TIMEOUT(15)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The ALU's answer for each function code. Code F never answers.
  function automatic logic [15:0] res_of(input logic [3:0] f);
    if (f == 4'h2) return 16'hA55A;
    return {f, ~f, f + 4'h3, f ^ 4'hC};
  endfunction

  // The ALU responder answers in the first WAIT cycle after it sees ALU_EN.
  bit         stub_armed;
  logic [3:0] stub_fun;
  initial begin
    stub_armed        = 1'b0;
    stub_fun          = '0;
    bus.i_alu_out_vld = 1'b0;
    bus.i_alu_out     = 16'h0BAD;
    forever begin
      @(posedge clk);
      #1;
      bus.i_alu_out_vld = 1'b0;
      bus.i_alu_out     = 16'h0BAD;
      if (rst) begin
        stub_armed = 1'b0;
      end else begin
        if (stub_armed) begin
          bus.i_alu_out_vld = 1'b1;
          bus.i_alu_out     = res_of(stub_fun);
          stub_armed        = 1'b0;
        end
        if (bus.o_alu_en && bus.o_alu_fun != 4'hF) begin
          stub_armed = 1'b1;
          stub_fun   = bus.o_alu_fun;
        end
      end
    end
  end

  // The reference model tracks pending commands, bytes owed to the FIFO, and the command in flight.
  logic [3:0] mq[$];
  logic [7:0] exp_b[$];
  bit         exp_hi[$];
  bit         outstanding  = 1'b0;
  bit         out_mute     = 1'b0;
  logic [3:0] out_fun      = '0;
  int         wait_cyc     = 0;
  logic [3:0] last_fun     = '0;
  bit         expect_issue = 1'b0;
  bit         prev_clk_en  = 1'b0;
  int         to_pulses    = 0;
  int         en_rises     = 0;
  int         write_cnt    = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        bit pop;
        bit push;
        pop  = 1'b0;
        push = bus.i_cmd_vld && (mq.size() != 4);
        chk("q_level", 32'(bus.o_q_level), mq.size());
        chk("cmd_rdy", 32'(bus.o_cmd_rdy), 32'(mq.size() != 4));
        if (!bus.o_busy)
          chk("idle_quiet", {bus.o_alu_clk_en, bus.o_alu_en, bus.o_wr_inc}, 0);
        if (bus.o_alu_en || bus.o_wr_inc) chk("clk_en_active", 32'(bus.o_alu_clk_en), 1);
        if (bus.o_wr_inc) chk("no_write_when_full", 32'(bus.i_fifo_full), 0);
        if (rst) chk("wr_inc_in_rst", 32'(bus.o_wr_inc), 0);
        if (expect_issue) chk("back_to_back_issue", 32'(bus.o_alu_en), 1);
        expect_issue = 1'b0;

        if (outstanding) begin
          wait_cyc++;
          if (out_mute) begin
            chk("timeout_err", 32'(bus.o_timeout_err), 32'(wait_cyc == 15));
            if (wait_cyc == 15) begin
              outstanding = 1'b0;
              pop         = 1'b1;
            end
          end else begin
            chk("timeout_err", 32'(bus.o_timeout_err), 0);
            if (bus.i_alu_out_vld) begin
              logic [15:0] r;
              r = res_of(out_fun);
              exp_b.push_back(r[7:0]);
              exp_hi.push_back(1'b0);
              exp_b.push_back(r[15:8]);
              exp_hi.push_back(1'b1);
              outstanding = 1'b0;
            end
          end
        end else begin
          chk("timeout_err", 32'(bus.o_timeout_err), 0);
        end

        if (bus.o_wr_inc) begin
          write_cnt++;
          if (exp_b.size() == 0) begin
            chk("unexpected_write", 32'(bus.o_wr_data), 32'hFFFF_FFFF);
          end else begin
            chk("wr_data", 32'(bus.o_wr_data), 32'(exp_b[0]));
            if (exp_hi[0]) pop = 1'b1;
            void'(exp_b.pop_front());
            void'(exp_hi.pop_front());
          end
        end else begin
          chk("wr_data_idle", 32'(bus.o_wr_data), 0);
        end

        if (bus.o_alu_en) begin
          if (mq.size() == 0 || outstanding) begin
            chk("spurious_issue", 32'(bus.o_alu_en), 0);
          end else begin
            chk("alu_fun", 32'(bus.o_alu_fun), 32'(mq[0]));
            last_fun    = mq[0];
            out_fun     = mq[0];
            out_mute    = (mq[0] == 4'hF);
            outstanding = 1'b1;
            wait_cyc    = 0;
          end
        end else begin
          chk("alu_fun_hold", 32'(bus.o_alu_fun), 32'(last_fun));
        end

        if (bus.o_timeout_err) to_pulses++;
        if (bus.o_alu_clk_en && !prev_clk_en) en_rises++;
        prev_clk_en = bus.o_alu_clk_en;

        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(bus.i_cmd_fun);
        if (pop && mq.size() != 0) expect_issue = 1'b1;

        if (rst) begin
          mq.delete();
          exp_b.delete();
          exp_hi.delete();
          outstanding  = 1'b0;
          expect_issue = 1'b0;
          last_fun     = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus.o_busy || bus.o_q_level != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_within_budget", 32'(n < budget), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_en;
    int base_wr;
    int base_to;
    int n;
    bus.i_cmd_vld   = 1'b0;
    bus.i_cmd_fun   = '0;
    bus.i_fifo_full = 1'b0;
    rst             = 1'b1;
    tick();
    started = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_cmd_rdy", 32'(bus.o_cmd_rdy), 1);
    chk("rst_q_level", 32'(bus.o_q_level), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_clk_en", 32'(bus.o_alu_clk_en), 0);
    chk("rst_alu_en", 32'(bus.o_alu_en), 0);
    chk("rst_wr_inc", 32'(bus.o_wr_inc), 0);
    chk("rst_alu_fun", 32'(bus.o_alu_fun), 0);

    // Single operation with its latency pinned cycle by cycle.
    bus.i_cmd_fun = 4'h2;
    bus.i_cmd_vld = 1'b1;
    tick();
    bus.i_cmd_vld = 1'b0;
    chk("single_t1_level", 32'(bus.o_q_level), 1);
    chk("single_t1_busy", 32'(bus.o_busy), 0);
    tick();
    chk("single_t2_gate", {bus.o_busy, bus.o_alu_clk_en, bus.o_alu_en}, 3'b110);
    tick();
    chk("single_t3_issue", {bus.o_alu_en, bus.o_alu_fun}, 5'h12);
    tick();
    chk("single_t4_wait", {bus.o_alu_en, bus.o_wr_inc}, 0);
    tick();
    chk("single_t5_lo", {bus.o_wr_inc, bus.o_wr_data}, 9'h15A);
    tick();
    chk("single_t6_hi", {bus.o_wr_inc, bus.o_wr_data}, 9'h1A5);
    chk("single_t6_level", 32'(bus.o_q_level), 1);
    tick();
    chk("single_t7_idle", {bus.o_busy, bus.o_alu_clk_en, bus.o_q_level}, 0);

    // Fill the queue: the 5th push is dropped and the clock gate opens once.
    base_en = en_rises;
    base_wr = write_cnt;
    bus.i_cmd_vld = 1'b1;
    bus.i_cmd_fun = 4'h1;
    tick();
    bus.i_cmd_fun = 4'h3;
    tick();
    bus.i_cmd_fun = 4'h5;
    tick();
    bus.i_cmd_fun = 4'h7;
    tick();
    chk("fill_rdy_low", 32'(bus.o_cmd_rdy), 0);
    chk("fill_level4", 32'(bus.o_q_level), 4);
    bus.i_cmd_fun = 4'h9;
    tick();
    bus.i_cmd_vld = 1'b0;
    chk("fill_5th_dropped", 32'(bus.o_q_level), 4);
    wait_idle(100);
    chk("fill_one_gate_on", en_rises - base_en, 1);
    chk("fill_writes", write_cnt - base_wr, 8);
    chk("fill_all_bytes_out", exp_b.size(), 0);

    // FIFO backpressure: SEND_LO held for 6 cycles, with res_of(6) = 16'h699A.
    bus.i_fifo_full = 1'b1;
    bus.i_cmd_fun   = 4'h6;
    bus.i_cmd_vld   = 1'b1;
    tick();
    bus.i_cmd_vld = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold", {bus.o_wr_inc, bus.o_busy, bus.o_alu_clk_en}, 3'b011);
      if (i < 5) tick();
    end
    bus.i_fifo_full = 1'b0;
    #1;
    chk("bp_lo", {bus.o_wr_inc, bus.o_wr_data}, 9'h19A);
    tick();
    chk("bp_hi", {bus.o_wr_inc, bus.o_wr_data}, 9'h169);
    wait_idle(20);

    // Timeout on code F, followed by a normal command.
    base_to = to_pulses;
    base_wr = write_cnt;
    bus.i_cmd_vld = 1'b1;
    bus.i_cmd_fun = 4'hF;
    tick();
    bus.i_cmd_fun = 4'h4;
    tick();
    bus.i_cmd_vld = 1'b0;
    wait_idle(100);
    chk("timeout_once", to_pulses - base_to, 1);
    chk("timeout_writes", write_cnt - base_wr, 2);

    // Push on the SEND_HI write cycle while two commands are queued.
    bus.i_cmd_vld = 1'b1;
    bus.i_cmd_fun = 4'hA;
    tick();
    bus.i_cmd_fun = 4'hB;
    tick();
    bus.i_cmd_vld = 1'b0;
    n = 0;
    while (!bus.o_wr_inc && n < 30) begin
      tick();
      n++;
    end
    chk("pp_reach_send", 32'(n < 30), 1);
    tick();
    chk("pp_send_hi", {bus.o_wr_inc, bus.o_q_level}, {1'b1, 3'd2});
    bus.i_cmd_vld = 1'b1;
    bus.i_cmd_fun = 4'hC;
    tick();
    bus.i_cmd_vld = 1'b0;
    chk("pp_level_kept", 32'(bus.o_q_level), 2);
    bus.i_cmd_vld = 1'b1;
    bus.i_cmd_fun = 4'hD;
    tick();
    bus.i_cmd_fun = 4'hE;
    tick();
    bus.i_cmd_fun = 4'h0;
    tick();
    bus.i_cmd_vld = 1'b0;
    wait_idle(150);
    chk("pp_all_bytes_out", exp_b.size(), 0);

    // Reset during SEND_LO with three commands queued.
    bus.i_fifo_full = 1'b1;
    bus.i_cmd_vld   = 1'b1;
    bus.i_cmd_fun   = 4'h1;
    tick();
    bus.i_cmd_fun = 4'h2;
    tick();
    bus.i_cmd_fun = 4'h3;
    tick();
    bus.i_cmd_vld = 1'b0;
    repeat (4) tick();
    chk("rmid_level3", 32'(bus.o_q_level), 3);
    chk("rmid_in_send", {bus.o_busy, bus.o_wr_inc}, 2'b10);
    rst             = 1'b1;
    bus.i_fifo_full = 1'b0;
    tick();
    rst = 1'b0;
    chk("rmid_after", {bus.o_q_level, bus.o_wr_inc, bus.o_alu_clk_en, bus.o_cmd_rdy}, 6'b000001);
    chk("rmid_busy", 32'(bus.o_busy), 0);
    base_wr = write_cnt;
    repeat (30) tick();
    chk("rmid_no_writes", write_cnt - base_wr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
